// File: rtl/wb_dma_xfer_eng.sv
// Single-channel block-transfer engine driving the DMA WISHBONE master port.
// Copies tot_sz words from src to dst as read/write pairs, with abort and bus-error termination.

module wb_dma_xfer_eng #(
    parameter int CNT_W   = 12,
    parameter int ADR_INC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_adr,
    input  logic [31:0]      dst_adr,
    input  logic [CNT_W-1:0] tot_sz,
    input  logic             src_inc,
    input  logic             dst_inc,
    input  logic             abort,
    input  logic             pause,
    output logic             mast_go,
    output logic             mast_we,
    output logic [31:0]      mast_adr,
    output logic [31:0]      mast_dout,
    input  logic [31:0]      mast_din,
    input  logic             mast_drdy,
    input  logic             mast_err,
    output logic             mast_wait,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] rem_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_GAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_NEXT = 3'd4
    } state_t;

    localparam logic [31:0]      ADR_STEP = 32'(ADR_INC);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r, state_s;
    logic [31:0]      src_r, src_s;
    logic [31:0]      dst_r, dst_s;
    logic [31:0]      data_r, data_s;
    logic [31:0]      adr_r, adr_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             src_inc_r, src_inc_s;
    logic             dst_inc_r, dst_inc_s;
    logic             go_r, go_s;
    logic             we_r, we_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             err_r, err_s;

    // Next-state and datapath update; abort outranks bus error, which outranks drdy.
    always_comb begin
        state_s   = state_r;
        src_s     = src_r;
        dst_s     = dst_r;
        data_s    = data_r;
        cnt_s     = cnt_r;
        src_inc_s = src_inc_r;
        dst_inc_s = dst_inc_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (tot_sz != CNT_ZERO) begin
                        src_s     = src_adr;
                        dst_s     = dst_adr;
                        cnt_s     = tot_sz;
                        src_inc_s = src_inc;
                        dst_inc_s = dst_inc;
                        state_s   = ST_RD;
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (mast_err) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else if (mast_drdy) begin
                    data_s  = mast_din;
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_WR: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (mast_err) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else if (mast_drdy) begin
                    state_s = ST_NEXT;
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_NEXT: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                    src_s = src_inc_r ? (src_r + ADR_STEP) : src_r;
                    dst_s = dst_inc_r ? (dst_r + ADR_STEP) : dst_r;
                    if (cnt_r == CNT_ONE) begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RD;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from the upcoming state so they are registered and stable per phase.
    always_comb begin
        go_s   = 1'b0;
        we_s   = 1'b0;
        adr_s  = adr_r;
        busy_s = 1'b1;
        case (state_s)
            ST_RD: begin
                go_s  = 1'b1;
                adr_s = src_s;
            end
            ST_WR: begin
                go_s  = 1'b1;
                we_s  = 1'b1;
                adr_s = dst_s;
            end
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            src_r     <= 32'h0000_0000;
            dst_r     <= 32'h0000_0000;
            data_r    <= 32'h0000_0000;
            adr_r     <= 32'h0000_0000;
            cnt_r     <= CNT_ZERO;
            src_inc_r <= 1'b0;
            dst_inc_r <= 1'b0;
            go_r      <= 1'b0;
            we_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            src_r     <= src_s;
            dst_r     <= dst_s;
            data_r    <= data_s;
            adr_r     <= adr_s;
            cnt_r     <= cnt_s;
            src_inc_r <= src_inc_s;
            dst_inc_r <= dst_inc_s;
            go_r      <= go_s;
            we_r      <= we_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

    assign mast_go   = go_r;
    assign mast_we   = we_r;
    assign mast_adr  = adr_r;
    assign mast_dout = data_r;
    assign mast_wait = pause;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign rem_cnt   = cnt_r;

endmodule

// File: tb/tb_wb_dma_xfer_eng.sv
// Randomized bench for wb_dma_xfer_eng: a responding bus slave records completed accesses,
// and a transfer-level model predicts the access list, completion pulses and remaining count.

module tb_wb_dma_xfer_eng;

    localparam int CNT_W = 12;
    localparam int INC   = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      src_adr;
    logic [31:0]      dst_adr;
    logic [CNT_W-1:0] tot_sz;
    logic             src_inc;
    logic             dst_inc;
    logic             abort;
    logic             pause;
    logic             mast_go;
    logic             mast_we;
    logic [31:0]      mast_adr;
    logic [31:0]      mast_dout;
    logic [31:0]      mast_din;
    logic             mast_drdy;
    logic             mast_err;
    logic             mast_wait;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] rem_cnt;

    int total = 0;
    int bad   = 0;

    // slave configuration, written by the main process only
    int          cfg_gen   = 0;
    int          cfg_lat   = 0;
    int          cfg_err_at = -1;
    int          cfg_abort_at = -1;
    logic        cfg_err_drdy = 1'b0;
    logic        cfg_abort_drdy = 1'b0;
    logic        cfg_force_abort = 1'b0;
    logic [31:0] cfg_seed = 32'h0;

    txn_t obs_q[$];
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   viol_cnt = 0;
    logic go_prev  = 1'b0;
    logic we_prev  = 1'b0;
    logic [31:0] adr_prev = 32'h0;
    logic [CNT_W-1:0] model_rem = '0;

    wb_dma_xfer_eng #(.CNT_W(CNT_W), .ADR_INC(INC)) dut (
        .clk(clk), .rst(rst), .start(start), .src_adr(src_adr), .dst_adr(dst_adr),
        .tot_sz(tot_sz), .src_inc(src_inc), .dst_inc(dst_inc), .abort(abort), .pause(pause),
        .mast_go(mast_go), .mast_we(mast_we), .mast_adr(mast_adr), .mast_dout(mast_dout),
        .mast_din(mast_din), .mast_drdy(mast_drdy), .mast_err(mast_err), .mast_wait(mast_wait),
        .busy(busy), .done(done), .err(err), .rem_cnt(rem_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse counters and protocol watch: phases must be separated by a low mast_go cycle.
    always @(negedge clk) begin
        go_prev  <= mast_go;
        we_prev  <= mast_we;
        adr_prev <= mast_adr;
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
        if ((done && err) || (mast_go && !busy) ||
            (go_prev && mast_go && (we_prev != mast_we || adr_prev != mast_adr)))
            viol_cnt <= viol_cnt + 1;
    end

    // Bus slave: answers each access after cfg_lat cycles, injecting error/abort on a chosen access.
    initial begin : slave
        int   dly;
        int   acc;
        int   gen_seen;
        logic go_seen;
        txn_t t;
        mast_drdy = 1'b0; mast_err = 1'b0; mast_din = 32'h0; abort = 1'b0;
        dly = -1; acc = 0; gen_seen = 0; go_seen = 1'b0;
        forever begin
            @(negedge clk);
            mast_drdy = 1'b0;
            mast_err  = 1'b0;
            abort     = cfg_force_abort;
            if (cfg_gen != gen_seen) begin
                gen_seen = cfg_gen;
                acc = 0;
            end
            if (!mast_go) begin
                go_seen = 1'b0;
                dly = -1;
            end else begin
                if (!go_seen) begin
                    go_seen = 1'b1;
                    dly = cfg_lat;
                end
                if (dly > 0) begin
                    dly--;
                end else if (dly == 0) begin
                    dly = -1;
                    if (!mast_we) mast_din = mast_adr ^ cfg_seed;
                    if (acc == cfg_abort_at) begin
                        abort = 1'b1;
                        mast_drdy = cfg_abort_drdy;
                    end else if (acc == cfg_err_at) begin
                        mast_err = 1'b1;
                        mast_drdy = cfg_err_drdy;
                    end else begin
                        mast_drdy = 1'b1;
                        t.we  = mast_we;
                        t.adr = mast_adr;
                        t.dat = mast_we ? mast_dout : mast_din;
                        obs_q.push_back(t);
                    end
                    acc++;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_rem = '0;
    endtask

    // One transfer: model predicts accesses (k_stop completed), then DUT run is compared.
    task automatic run_xfer(input string name, input logic [31:0] s, input logic [31:0] d,
                            input int n, input logic si, input logic di, input int lat,
                            input int e_at, input logic e_drdy, input int a_at, input logic a_drdy,
                            input logic [31:0] seed, input logic poke);
        txn_t exp_q[$];
        txn_t t;
        int   k_stop, term, w, base, dc0, ec0, vc0, nobs;
        logic fin;
        logic [31:0] ra;
        k_stop = 2 * n;
        term   = 0;
        if (e_at >= 0 && e_at < k_stop) begin k_stop = e_at; term = 1; end
        if (a_at >= 0 && a_at < k_stop) begin k_stop = a_at; term = 2; end
        for (int k = 0; k < k_stop; k++) begin
            w  = k / 2;
            ra = s + (si ? 32'(INC * w) : 32'h0);
            if (k % 2 == 0) begin
                t.we = 1'b0; t.adr = ra;
            end else begin
                t.we = 1'b1; t.adr = d + (di ? 32'(INC * w) : 32'h0);
            end
            t.dat = ra ^ seed;
            exp_q.push_back(t);
        end
        if (n > 0) model_rem = (term == 0) ? CNT_W'(0) : CNT_W'(n - k_stop / 2);

        cfg_lat = lat; cfg_err_at = e_at; cfg_err_drdy = e_drdy;
        cfg_abort_at = a_at; cfg_abort_drdy = a_drdy; cfg_seed = seed;
        cfg_gen++;
        base = obs_q.size();
        dc0 = done_cnt; ec0 = err_cnt; vc0 = viol_cnt;
        src_adr = s; dst_adr = d; tot_sz = CNT_W'(n); src_inc = si; dst_inc = di;
        start = 1'b1;
        fin = 1'b0;
        for (int i = 0; i < 4000 && !fin; i++) begin
            @(negedge clk);
            if (!busy) begin
                fin = 1'b1;
                start = 1'b0;
            end else if (poke && i == 2) begin
                start = 1'b1;
                src_adr = $urandom; dst_adr = $urandom;
                tot_sz = CNT_W'($urandom_range(1, 50));
                src_inc = ~si; dst_inc = ~di;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({name, " finish"}, fin, 1'b1);
        if (!fin) do_reset();
        @(negedge clk);
        @(negedge clk);
        nobs = obs_q.size() - base;
        chk({name, " n_access"}, nobs, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < nobs; i++) begin
            chk($sformatf("%s acc%0d we", name, i), obs_q[base + i].we, exp_q[i].we);
            chk($sformatf("%s acc%0d adr", name, i), obs_q[base + i].adr, exp_q[i].adr);
            chk($sformatf("%s acc%0d dat", name, i), obs_q[base + i].dat, exp_q[i].dat);
        end
        chk({name, " done_pulses"}, done_cnt - dc0, (term == 0) ? 1 : 0);
        chk({name, " err_pulses"}, err_cnt - ec0, (term == 1) ? 1 : 0);
        chk({name, " rem_cnt"}, rem_cnt, model_rem);
        chk({name, " idle_go"}, {busy, mast_go}, 2'b00);
        chk({name, " protocol"}, viol_cnt - vc0, 0);
    endtask

    initial begin : main
        int n, mode, e_at, a_at, dc0, ec0;
        logic fin;
        logic [31:0] s;
        rst = 1'b1; start = 1'b0; src_adr = 32'h0; dst_adr = 32'h0; tot_sz = '0;
        src_inc = 1'b0; dst_inc = 1'b0; pause = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset outputs", {mast_go, mast_we, busy, done, err, mast_adr, mast_dout, rem_cnt},
            {5'b0, 32'h0, 32'h0, 12'h0});
        rst = 1'b0;

        pause = 1'b1; #1 chk("wait_hi", mast_wait, 1'b1);
        pause = 1'b0; #1 chk("wait_lo", mast_wait, 1'b0);

        run_xfer("single", 32'h100, 32'h200, 1, 1'b0, 1'b0, 2, -1, 1'b0, -1, 1'b0,
                 32'hDEADBEEF ^ 32'h100, 1'b0);
        chk("single rdata", obs_q[0].dat, 32'hDEADBEEF);
        run_xfer("block4", 32'h1000, 32'h2000, 4, 1'b1, 1'b1, 2, -1, 1'b0, -1, 1'b0,
                 32'h1234_5678, 1'b0);
        run_xfer("err_w2", 32'h300, 32'h400, 3, 1'b1, 1'b1, 1, 3, 1'b0, -1, 1'b0,
                 32'h0F0F_0F0F, 1'b0);
        run_xfer("abort_r1", 32'h500, 32'h600, 5, 1'b1, 1'b0, 1, -1, 1'b0, 0, 1'b1,
                 32'hA5A5_A5A5, 1'b0);
        run_xfer("zero", 32'h700, 32'h800, 0, 1'b1, 1'b1, 0, -1, 1'b0, -1, 1'b0,
                 32'h0, 1'b0);
        run_xfer("poke", 32'hFFFF_FFF8, 32'h900, 4, 1'b1, 1'b1, 1, -1, 1'b0, -1, 1'b0,
                 32'h5555_AAAA, 1'b1);

        // start together with abort in IDLE must be ignored
        dc0 = done_cnt;
        @(posedge clk);
        cfg_force_abort = 1'b1;
        @(negedge clk);
        tot_sz = CNT_W'(2); start = 1'b1;
        @(negedge clk);
        start = 1'b0; cfg_force_abort = 1'b0;
        chk("abort_start busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_start done", done_cnt - dc0, 0);

        // synchronous reset in the middle of a write phase
        cfg_lat = 3; cfg_err_at = -1; cfg_abort_at = -1; cfg_gen++;
        src_adr = 32'hA00; dst_adr = 32'hB00; tot_sz = CNT_W'(3); src_inc = 1'b1; dst_inc = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            if (mast_go && mast_we) fin = 1'b1;
        end
        chk("rst_mid reach_wr", fin, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid outputs", {mast_go, mast_we, busy, done, err, mast_adr, mast_dout, rem_cnt},
            {5'b0, 32'h0, 32'h0, 12'h0});
        rst = 1'b0;
        model_rem = '0;
        run_xfer("after_rst", 32'hC00, 32'hD00, 2, 1'b1, 1'b0, 0, -1, 1'b0, -1, 1'b0,
                 32'h7777_1111, 1'b0);

        for (int r = 0; r < 40; r++) begin
            n    = $urandom_range(0, 6);
            mode = (n == 0) ? 0 : $urandom_range(0, 3);
            e_at = (mode == 2) ? $urandom_range(0, 2 * n - 1) : -1;
            a_at = (mode == 3) ? $urandom_range(0, 2 * n - 1) : -1;
            s    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            run_xfer($sformatf("rnd%0d", r), s, $urandom, n, 1'($urandom), 1'($urandom),
                     $urandom_range(0, 3), e_at, 1'($urandom), a_at, 1'($urandom),
                     $urandom, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
